// File: rtl/uart_frame_tx.sv
// uart_frame_tx: multi-byte UART transmitter.
// Takes one frame (up to NBYTES bytes + runtime length) over valid/ready and
// sends it as back-to-back 8-bit characters: start, 8 data LSB first,
// optional parity, STOP_BITS stop bits. txd is registered and idles high.
// Optional build macro: UART_CR_TERM_EN appends a 0x0D character to every frame.
module uart_frame_tx #(
  parameter int CLKS_PER_BIT = 1085,
  parameter int NBYTES       = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*NBYTES-1:0]   frame_data,
  input  logic [4:0]            frame_len,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  txd
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Latched frame: payload plus clamped length, frozen for the whole frame.
  typedef struct packed {
    logic [8*NBYTES-1:0] data;
    logic [4:0]          len;
  } frame_req_t;

  state_t     state_q, state_nxt;
  logic [BW-1:0] baud_q, baud_nxt;
  logic [2:0] bit_q, bit_nxt;     // data bit index, reused as stop-bit index
  logic [4:0] byte_q, byte_nxt;   // 5 bits so a 16-byte frame (+terminator) never wraps
  frame_req_t req_q;
  logic       txd_q, txd_nxt;
  logic       done_q, done_nxt;
  logic       load;
  logic [4:0] len_in;
  logic       bit_end;
  logic       last_char;
  logic [7:0] cur_byte;
  logic       par_bit;

  // Length 0 or beyond the buffer means "whole buffer".
  assign len_in = (frame_len == 5'd0 || frame_len > 5'(NBYTES)) ? 5'(NBYTES) : frame_len;

  assign bit_end = (baud_q == BW'(CLKS_PER_BIT - 1));

  // Character currently on the wire; byte 0 lives in the top bits.
  always_comb begin
    cur_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++)
      if (byte_q == 5'(i)) cur_byte = req_q.data[8*(NBYTES-1-i) +: 8];
`ifdef UART_CR_TERM_EN
    if (byte_q == req_q.len) cur_byte = 8'h0D;
`endif
  end

`ifdef UART_CR_TERM_EN
  assign last_char = (byte_q == req_q.len);
`else
  assign last_char = (byte_q == req_q.len - 5'd1);
`endif

  // Odd parity inverts the XOR reduction so the total count of ones is odd.
  assign par_bit = (PARITY == 1) ? ~(^cur_byte) : (^cur_byte);

  // State, counters, buffer and registered line outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      req_q   <= '0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      baud_q  <= baud_nxt;
      bit_q   <= bit_nxt;
      byte_q  <= byte_nxt;
      txd_q   <= txd_nxt;
      done_q  <= done_nxt;
      if (load) req_q <= '{data: frame_data, len: len_in};
    end
  end

  // Next state; txd_nxt is the level of the bit that starts on this edge,
  // which keeps txd a pure register with no output decode.
  always_comb begin
    state_nxt = state_q;
    baud_nxt  = (state_q == S_IDLE || bit_end) ? '0 : baud_q + BW'(1);
    bit_nxt   = bit_q;
    byte_nxt  = byte_q;
    txd_nxt   = txd_q;
    done_nxt  = 1'b0;
    load      = 1'b0;
    case (state_q)
      S_IDLE: begin
        txd_nxt = 1'b1;
        if (frame_valid) begin
          load      = 1'b1;
          state_nxt = S_START;
          byte_nxt  = '0;
          txd_nxt   = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_nxt = S_DATA;
          bit_nxt   = '0;
          txd_nxt   = cur_byte[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            bit_nxt = '0;
            if (PARITY != 0) begin
              state_nxt = S_PARITY;
              txd_nxt   = par_bit;
            end else begin
              state_nxt = S_STOP;
              txd_nxt   = 1'b1;
            end
          end else begin
            bit_nxt = bit_q + 3'd1;
            txd_nxt = cur_byte[bit_q + 3'd1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_nxt = S_STOP;
          bit_nxt   = '0;
          txd_nxt   = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == 3'(STOP_BITS - 1)) begin
            bit_nxt = '0;
            if (last_char) begin
              state_nxt = S_IDLE;
              done_nxt  = 1'b1;
              txd_nxt   = 1'b1;
            end else begin
              state_nxt = S_START;
              byte_nxt  = byte_q + 5'd1;
              txd_nxt   = 1'b0;
            end
          end else begin
            bit_nxt = bit_q + 3'd1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign frame_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign txd         = txd_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: scoreboard bench for uart_frame_tx with CLKS_PER_BIT=4, NBYTES=8.
// Three instances: d0 no parity/1 stop, d1 even parity/2 stop, d2 odd parity/1 stop.
// Expected characters are pushed when a frame is offered and popped as the line is decoded.
module tb_uart_frame_tx;
  localparam int CPB = 4;
  localparam int NB  = 8;

  typedef struct {
    logic [11:0] bits;
    int          nbits;
  } ch_t;

  logic        clk, rst;
  logic [63:0] frame_data;
  logic [4:0]  frame_len;
  logic [2:0]  vld;
  logic rdy0, bsy0, dn0, txd0;
  logic rdy1, bsy1, dn1, txd1;
  logic rdy2, bsy2, dn2, txd2;

  int   n_chk  = 0;
  int   n_fail = 0;
  ch_t  q[$];
  int   exp_busy;

  uart_frame_tx #(.CLKS_PER_BIT(CPB), .NBYTES(NB), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .frame_data(frame_data), .frame_len(frame_len),
    .frame_valid(vld[0]), .frame_ready(rdy0), .busy(bsy0), .done(dn0), .txd(txd0));
  uart_frame_tx #(.CLKS_PER_BIT(CPB), .NBYTES(NB), .PARITY(2), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .frame_data(frame_data), .frame_len(frame_len),
    .frame_valid(vld[1]), .frame_ready(rdy1), .busy(bsy1), .done(dn1), .txd(txd1));
  uart_frame_tx #(.CLKS_PER_BIT(CPB), .NBYTES(NB), .PARITY(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .frame_data(frame_data), .frame_len(frame_len),
    .frame_valid(vld[2]), .frame_ready(rdy2), .busy(bsy2), .done(dn2), .txd(txd2));

  always #5 clk = ~clk;

  function automatic logic g_txd(int d);
    return (d == 0) ? txd0 : (d == 1) ? txd1 : txd2;
  endfunction
  function automatic logic g_busy(int d);
    return (d == 0) ? bsy0 : (d == 1) ? bsy1 : bsy2;
  endfunction
  function automatic logic g_done(int d);
    return (d == 0) ? dn0 : (d == 1) ? dn1 : dn2;
  endfunction
  function automatic logic g_rdy(int d);
    return (d == 0) ? rdy0 : (d == 1) ? rdy1 : rdy2;
  endfunction

  // Reference character: start, data LSB first, parity, stop bits.
  function automatic ch_t make_char(int d, logic [7:0] b);
    ch_t c;
    int  par, stp, k;
    par = (d == 0) ? 0 : (d == 1) ? 2 : 1;
    stp = (d == 1) ? 2 : 1;
    c.bits = '0;
    c.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) c.bits[1+i] = b[i];
    k = 9;
    if (par != 0) begin
      c.bits[k] = (par == 1) ? ~(^b) : (^b);
      k++;
    end
    for (int s = 0; s < stp; s++) begin
      c.bits[k] = 1'b1;
      k++;
    end
    c.nbits = k;
    return c;
  endfunction

  task automatic push_frame(input int d, input logic [63:0] data, input int len);
    int  n;
    ch_t c;
    n = (len == 0 || len > NB) ? NB : len;
    for (int i = 0; i < n; i++) begin
      c = make_char(d, data[63-8*i -: 8]);
      q.push_back(c);
      exp_busy += c.nbits * CPB;
    end
`ifdef UART_CR_TERM_EN
    c = make_char(d, 8'h0D);
    q.push_back(c);
    exp_busy += c.nbits * CPB;
`endif
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of start-bit cycle 0.
  task automatic offer(input int d, input logic [63:0] data, input int len, input bit hold);
    frame_data = data;
    frame_len  = 5'(len);
    vld[d]     = 1'b1;
    exp_busy   = 0;
    push_frame(d, data, len);
    @(negedge clk);
    if (!hold) vld[d] = 1'b0;
  endtask

  // Pops every queued character and decodes it from txd, one sample per cycle.
  // A bit whose samples disagree across its CPB cycles decodes as X.
  task automatic drain(input int d, output int nchar, output int bad, output int busy_n,
                       output int done_n, output logic [11:0] obs0,
                       output logic [11:0] bad_obs, output logic [11:0] bad_exp);
    ch_t         c;
    logic [11:0] obs;
    logic        v;
    nchar = 0; bad = 0; busy_n = 0; done_n = 0;
    obs0 = '0; bad_obs = '0; bad_exp = '0;
    while (q.size() > 0) begin
      c   = q.pop_front();
      obs = '0;
      for (int k = 0; k < c.nbits; k++) begin
        v = g_txd(d);
        for (int cy = 0; cy < CPB; cy++) begin
          if (g_txd(d) !== v) v = 1'bx;
          if (g_busy(d)) busy_n++;
          if (g_done(d)) done_n++;
          @(negedge clk);
        end
        obs[k] = v;
      end
      if (nchar == 0) obs0 = obs;
      if (obs !== c.bits) begin
        if (bad == 0) begin
          bad_obs = obs;
          bad_exp = c.bits;
        end
        bad++;
      end
      nchar++;
    end
  endtask

  int n_exp_chars;
  initial begin
`ifdef UART_CR_TERM_EN
    n_exp_chars = 1;
`else
    n_exp_chars = 0;
`endif
  end

  task automatic test_reset();
    int dcnt;
    @(negedge clk);
    n_chk++; if (txd0 !== 1'b1) begin n_fail++; $display("FAIL reset_txd got %b want 1", txd0); end
    n_chk++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", rdy0); end
    n_chk++; if (bsy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bsy0); end
    n_chk++; if (dn0 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", dn0); end
    n_chk++; if ({txd1, txd2, rdy1, rdy2} !== 4'b1111) begin
      n_fail++; $display("FAIL reset_others got %b want 1111", {txd1, txd2, rdy1, rdy2}); end
    rst = 1'b0;
    @(negedge clk);
    // Abandon a frame in the middle of data bit 1 of 0x41 (a zero on the line).
    offer(0, {8'h41, 56'h0}, 1, 1'b0);
    repeat (9) @(negedge clk);
    n_chk++; if (txd0 !== 1'b0 || bsy0 !== 1'b1) begin
      n_fail++; $display("FAIL midframe_pre got txd=%b busy=%b want txd=0 busy=1", txd0, bsy0); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if (txd0 !== 1'b1) begin n_fail++; $display("FAIL midreset_txd got %b want 1", txd0); end
    n_chk++; if (bsy0 !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", bsy0); end
    n_chk++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL midreset_ready got %b want 1", rdy0); end
    q.delete();
    dcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (dn0) dcnt++;
    end
    rst = 1'b0;
    repeat (2 * CPB) begin
      @(negedge clk);
      if (dn0 || bsy0 || !txd0) dcnt++;
    end
    n_chk++; if (dcnt !== 0) begin n_fail++; $display("FAIL midreset_quiet got %0d active cycles want 0", dcnt); end
  endtask

  task automatic test_frame(input string nm, input int d, input logic [63:0] data,
                            input int len, input int want_chars);
    int nchar, bad, busy_n, done_n, eb;
    logic [11:0] obs0, bo, be;
    n_chk++; if (g_rdy(d) !== 1'b1) begin n_fail++; $display("FAIL %s_ready got %b want 1", nm, g_rdy(d)); end
    offer(d, data, len, 1'b0);
    eb = exp_busy;
    drain(d, nchar, bad, busy_n, done_n, obs0, bo, be);
    n_chk++; if (bad !== 0) begin
      n_fail++; $display("FAIL %s_chars %0d bad, got %b want %b", nm, bad, bo, be); end
    n_chk++; if (nchar !== want_chars + n_exp_chars) begin
      n_fail++; $display("FAIL %s_count got %0d want %0d", nm, nchar, want_chars + n_exp_chars); end
    n_chk++; if (busy_n !== eb || done_n !== 0) begin
      n_fail++; $display("FAIL %s_busy got busy=%0d done=%0d want busy=%0d done=0", nm, busy_n, done_n, eb); end
    n_chk++; if (g_done(d) !== 1'b1 || g_busy(d) !== 1'b0 || g_rdy(d) !== 1'b1) begin
      n_fail++; $display("FAIL %s_done got done=%b busy=%b ready=%b want 1 0 1", nm, g_done(d), g_busy(d), g_rdy(d)); end
    @(negedge clk);
    n_chk++; if (g_done(d) !== 1'b0 || g_txd(d) !== 1'b1) begin
      n_fail++; $display("FAIL %s_after got done=%b txd=%b want 0 1", nm, g_done(d), g_txd(d)); end
    if (d == 0 && len == 1 && data[63:56] == 8'h41) begin
      n_chk++; if (obs0[9:0] !== 10'b1_0100_0001_0) begin
        n_fail++; $display("FAIL %s_pattern got %b want 1010000010", nm, obs0[9:0]); end
    end
    if (d == 1) begin
      n_chk++; if (obs0[11:9] !== 3'b111) begin
        n_fail++; $display("FAIL %s_even_par got %b want 111", nm, obs0[11:9]); end
    end
    if (d == 2) begin
      n_chk++; if (obs0[10:9] !== 2'b10) begin
        n_fail++; $display("FAIL %s_odd_par got %b want 10", nm, obs0[10:9]); end
    end
  endtask

  task automatic test_single_byte();
    test_frame("single", 0, {8'h41, 56'h0}, 1, 1);
  endtask

  task automatic test_multi_byte();
    test_frame("multi", 0, 64'h0123456789ABCDEF, 8, 8);
  endtask

  task automatic test_parity();
    test_frame("even2stop", 1, {8'h07, 56'h0}, 1, 1);
    test_frame("odd", 2, {8'h07, 56'h0}, 1, 1);
  endtask

  task automatic test_clamp();
    test_frame("len0", 0, 64'hA55A_0FF0_C33C_1EE1, 0, 8);
    test_frame("len20", 0, 64'h8001_7E81_2442_DB00, 20, 8);
  endtask

  // Valid stays high across the whole first frame while the inputs change;
  // the second frame must be taken on the done cycle and start right after it.
  task automatic test_back_to_back();
    int nchar, bad, busy_n, done_n;
    logic [11:0] obs0, bo, be;
    offer(0, {16'hC3_5A, 48'h0}, 2, 1'b1);
    frame_data = {8'h96, 56'h0123456789ABCD};
    frame_len  = 5'd1;
    drain(0, nchar, bad, busy_n, done_n, obs0, bo, be);
    n_chk++; if (bad !== 0 || nchar !== 2 + n_exp_chars) begin
      n_fail++; $display("FAIL b2b_first got %0d bad of %0d, got %b want %b", bad, nchar, bo, be); end
    n_chk++; if (done_n !== 0) begin n_fail++; $display("FAIL b2b_early_done got %0d want 0", done_n); end
    n_chk++; if (dn0 !== 1'b1 || rdy0 !== 1'b1) begin
      n_fail++; $display("FAIL b2b_handoff got done=%b ready=%b want 1 1", dn0, rdy0); end
    exp_busy = 0;
    push_frame(0, frame_data, 1);
    @(negedge clk);
    vld[0] = 1'b0;
    n_chk++; if (bsy0 !== 1'b1 || txd0 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_restart got busy=%b txd=%b want 1 0", bsy0, txd0); end
    drain(0, nchar, bad, busy_n, done_n, obs0, bo, be);
    n_chk++; if (bad !== 0 || nchar !== 1 + n_exp_chars) begin
      n_fail++; $display("FAIL b2b_second got %0d bad of %0d, got %b want %b", bad, nchar, bo, be); end
    n_chk++; if (dn0 !== 1'b1 || bsy0 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done got done=%b busy=%b want 1 0", dn0, bsy0); end
    @(negedge clk);
  endtask

  initial begin
    clk        = 1'b0;
    rst        = 1'b1;
    vld        = 3'b000;
    frame_data = '0;
    frame_len  = '0;
    exp_busy   = 0;
    repeat (2) @(posedge clk);
    test_reset();
    test_single_byte();
    test_multi_byte();
    test_parity();
    test_clamp();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
